// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer swap sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fb_pkg;

    // Sequencer states: idle, waiting for the next VBlank edge to swap, clearing the back buffer
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VB = 2'd1,
        CLEAR   = 2'd2
    } swap_state_t;

    // Command register bit positions
    localparam int CMD_SWAP_BIT  = 0;
    localparam int CMD_CLEAR_BIT = 1;
    localparam int CMD_NMIEN_BIT = 2;

    // Control register select values
    localparam logic CTRL_SEL_CMD    = 1'b0;
    localparam logic CTRL_SEL_COLOUR = 1'b1;

    // Default geometry: 32K x 8 per buffer, 160x120 visible words, 8-cycle NMI
    localparam int FB_ADDR_W      = 15;
    localparam int FB_CLEAR_WORDS = 19200;
    localparam int FB_NMI_LEN     = 8;

endpackage

// File: rtl/fb_nmi_pulse.sv
// VBlank NMI pulse generator: a VBlank rising edge with NMI enabled gives an NMI_LEN-cycle low pulse.
// Latency: NMI_n_o goes low the cycle after the qualifying edge.
// Backpressure: none; edges arriving while the pulse is active are ignored (no restart, no queueing).
module fb_nmi_pulse #(
    parameter int NMI_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic vb_rise_i,
    input  logic nmi_en_i,
    output logic nmi_n_o
);

    localparam int CNT_W = $clog2(NMI_LEN + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             nmi_n_q, nmi_n_d;

    // Down-counter holds the remaining low cycles; it only reloads once the pulse has finished
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else if (vb_rise_i && nmi_en_i) begin
            cnt_d = CNT_W'(NMI_LEN);
        end
        nmi_n_d = (cnt_d == '0);
    end

    // Counter and registered active-low output
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            nmi_n_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            nmi_n_q <= nmi_n_d;
        end
    end

    assign nmi_n_o = nmi_n_q;

endmodule

// File: rtl/fb_swap_sequencer.sv
// Double-buffer swap sequencer: swaps only at VBlank start, clears the back buffer, arbitrates the SRAM write port, raises NMI.
// Latency: memory write outputs 1 cycle after a CPU strobe or clear grant; swap lands 1 cycle after the VBlank edge.
// Backpressure: CPU writes always win the port and are never dropped; the clear engine stalls (address holds) on CPU cycles.
module fb_swap_sequencer
    import fb_pkg::*;
#(
    parameter int ADDR_W      = FB_ADDR_W,
    parameter int CLEAR_WORDS = FB_CLEAR_WORDS,
    parameter int NMI_LEN     = FB_NMI_LEN
) (
    input  logic              Clock_i,
    input  logic              Reset_i,
    input  logic              VBlank_i,
    input  logic              CpuWrReq_i,
    input  logic [ADDR_W-1:0] CpuAddr_i,
    input  logic [7:0]        CpuData_i,
    input  logic              CtrlWrite_i,
    input  logic              CtrlAddr_i,
    input  logic [7:0]        CtrlData_i,
    output logic              MemWe_o,
    output logic [ADDR_W-1:0] MemAddr_o,
    output logic [7:0]        MemData_o,
    output logic              BufSel_o,
    output logic              NMI_n_o,
    output logic              Busy_o,
    output logic [7:0]        FrameCount_o
);

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CLEAR_WORDS - 1);

    swap_state_t       state_q, state_d;
    logic              vblank_q;
    logic              vb_rise;
    logic              swap_pend_q, swap_pend_d;
    logic              clear_pend_q, clear_pend_d;
    logic              nmi_en_q, nmi_en_d;
    logic [7:0]        colour_q, colour_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              buf_sel_q, buf_sel_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              busy_q, busy_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_data_q, mem_data_d;

    logic              cmd_wr;
    logic              colour_wr;
    logic              swap_set;
    logic              clear_set;
    logic              clear_start;
    logic              clear_grant;

    assign vb_rise   = VBlank_i & ~vblank_q;
    assign cmd_wr    = CtrlWrite_i && (CtrlAddr_i == CTRL_SEL_CMD);
    assign colour_wr = CtrlWrite_i && (CtrlAddr_i == CTRL_SEL_COLOUR);
    assign swap_set  = cmd_wr && CtrlData_i[CMD_SWAP_BIT];
    assign clear_set = cmd_wr && CtrlData_i[CMD_CLEAR_BIT];

    // Control registers: NMI enable follows every command write, colour register is a plain load
    always_comb begin
        nmi_en_d = nmi_en_q;
        colour_d = colour_q;
        if (cmd_wr) begin
            nmi_en_d = CtrlData_i[CMD_NMIEN_BIT];
        end
        if (colour_wr) begin
            colour_d = CtrlData_i;
        end
    end

    // Sequencer next state: pending flags only set by commands, consumed by the FSM; a new
    // request landing in the same cycle the flag is consumed is kept rather than lost
    always_comb begin
        state_d      = state_q;
        swap_pend_d  = swap_pend_q | swap_set;
        clear_pend_d = clear_pend_q | clear_set;
        clr_addr_d   = clr_addr_q;
        buf_sel_d    = buf_sel_q;
        frame_cnt_d  = frame_cnt_q;
        clear_start  = 1'b0;
        clear_grant  = 1'b0;

        case (state_q)
            IDLE: begin
                // Swap has priority so a combined swap+clear clears the new back buffer
                if (swap_pend_q) begin
                    state_d = WAIT_VB;
                end else if (clear_pend_q) begin
                    state_d     = CLEAR;
                    clear_start = 1'b1;
                end
            end
            WAIT_VB: begin
                if (vb_rise) begin
                    buf_sel_d   = ~buf_sel_q;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    swap_pend_d = swap_set;
                    if (clear_pend_q) begin
                        state_d     = CLEAR;
                        clear_start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            CLEAR: begin
                // CPU cycles steal the port; the clear address simply holds
                if (!CpuWrReq_i) begin
                    clear_grant = 1'b1;
                    clr_addr_d  = clr_addr_q + 1'b1;
                    if (clr_addr_q == CLR_LAST) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clear_start) begin
            clr_addr_d   = '0;
            clear_pend_d = clear_set;
        end
    end

    // Busy reflects the registered state, so it is derived from the next-state values
    always_comb begin
        busy_d = swap_pend_d | clear_pend_d | (state_d != IDLE);
    end

    // Write-port arbiter: CPU first, then clear engine; address/data hold when the port is idle
    always_comb begin
        mem_we_d   = CpuWrReq_i | clear_grant;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        if (CpuWrReq_i) begin
            mem_addr_d = CpuAddr_i;
            mem_data_d = CpuData_i;
        end else if (clear_grant) begin
            mem_addr_d = clr_addr_q;
            mem_data_d = colour_q;
        end
    end

    // FSM state register
    always_ff @(posedge Clock_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, control and output registers
    always_ff @(posedge Clock_i or posedge Reset_i) begin
        if (Reset_i) begin
            vblank_q     <= 1'b0;
            swap_pend_q  <= 1'b0;
            clear_pend_q <= 1'b0;
            nmi_en_q     <= 1'b0;
            colour_q     <= 8'h00;
            clr_addr_q   <= '0;
            buf_sel_q    <= 1'b0;
            frame_cnt_q  <= 8'h00;
            busy_q       <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= 8'h00;
        end else begin
            vblank_q     <= VBlank_i;
            swap_pend_q  <= swap_pend_d;
            clear_pend_q <= clear_pend_d;
            nmi_en_q     <= nmi_en_d;
            colour_q     <= colour_d;
            clr_addr_q   <= clr_addr_d;
            buf_sel_q    <= buf_sel_d;
            frame_cnt_q  <= frame_cnt_d;
            busy_q       <= busy_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

    fb_nmi_pulse #(
        .NMI_LEN (NMI_LEN)
    ) u_nmi (
        .clk_i     (Clock_i),
        .rst_i     (Reset_i),
        .vb_rise_i (vb_rise),
        .nmi_en_i  (nmi_en_q),
        .nmi_n_o   (NMI_n_o)
    );

    assign MemWe_o      = mem_we_q;
    assign MemAddr_o    = mem_addr_q;
    assign MemData_o    = mem_data_q;
    assign BufSel_o     = buf_sel_q;
    assign Busy_o       = busy_q;
    assign FrameCount_o = frame_cnt_q;

endmodule

// File: tb/tb_fb_swap_sequencer.sv
// Self-checking bench for fb_swap_sequencer with a small clear size.
// Latency: n/a.
// Backpressure: n/a.
module tb_fb_swap_sequencer;

    localparam int ADDR_W = 15;
    localparam int CW     = 16;
    localparam int NL     = 8;

    logic              Clock = 1'b0;
    logic              Reset;
    logic              VBlank;
    logic              CpuWrReq;
    logic [ADDR_W-1:0] CpuAddr;
    logic [7:0]        CpuData;
    logic              CtrlWrite;
    logic              CtrlAddr;
    logic [7:0]        CtrlData;
    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [7:0]        MemData;
    logic              BufSel;
    logic              NMI_n;
    logic              Busy;
    logic [7:0]        FrameCount;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model of the visible swap state
    int   exp_fc;
    logic exp_bs;

    fb_swap_sequencer #(
        .ADDR_W      (ADDR_W),
        .CLEAR_WORDS (CW),
        .NMI_LEN     (NL)
    ) dut (
        .Clock_i      (Clock),
        .Reset_i      (Reset),
        .VBlank_i     (VBlank),
        .CpuWrReq_i   (CpuWrReq),
        .CpuAddr_i    (CpuAddr),
        .CpuData_i    (CpuData),
        .CtrlWrite_i  (CtrlWrite),
        .CtrlAddr_i   (CtrlAddr),
        .CtrlData_i   (CtrlData),
        .MemWe_o      (MemWe),
        .MemAddr_o    (MemAddr),
        .MemData_o    (MemData),
        .BufSel_o     (BufSel),
        .NMI_n_o      (NMI_n),
        .Busy_o       (Busy),
        .FrameCount_o (FrameCount)
    );

    always #5 Clock = ~Clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic ctrl_wr(input logic a, input logic [7:0] d);
        CtrlWrite = 1'b1;
        CtrlAddr  = a;
        CtrlData  = d;
        tick();
        CtrlWrite = 1'b0;
        CtrlData  = 8'h00;
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
        exp_fc = 0;
        exp_bs = 1'b0;
    endtask

    // Clear run: the model merges CPU slots and clear words into the expected write stream
    task automatic run_clear(input logic [7:0] colour, input logic [63:0] mask,
                             input bit rand_cpu, input string tag);
        logic [ADDR_W-1:0] eaddr[$];
        logic [7:0]        edata[$];
        logic [ADDR_W-1:0] caddr[64];
        logic [7:0]        cdata[64];
        int word = 0;
        int steps = 0;
        while (word < CW && steps < 64) begin
            if (mask[steps]) begin
                caddr[steps] = rand_cpu ? ADDR_W'($urandom) : 15'h7FFF;
                cdata[steps] = rand_cpu ? 8'($urandom) : 8'h55;
                eaddr.push_back(caddr[steps]);
                edata.push_back(cdata[steps]);
            end else begin
                caddr[steps] = '0;
                cdata[steps] = 8'h00;
                eaddr.push_back(ADDR_W'(word));
                edata.push_back(colour);
                word++;
            end
            steps++;
        end
        ctrl_wr(1'b1, colour);
        ctrl_wr(1'b0, 8'h02);
        tick();
        n_cmp++;
        if (MemWe !== 1'b0) begin
            n_fail++;
            $display("FAIL %s pre-clear we: got %b want 0", tag, MemWe);
        end
        for (int i = 0; i < steps + 2; i++) begin
            if (i < steps && mask[i]) begin
                CpuWrReq = 1'b1;
                CpuAddr  = caddr[i];
                CpuData  = cdata[i];
            end else begin
                CpuWrReq = 1'b0;
                CpuAddr  = '0;
                CpuData  = 8'h00;
            end
            tick();
            n_cmp++;
            if (i < steps) begin
                if (MemWe !== 1'b1 || MemAddr !== eaddr[i] || MemData !== edata[i]) begin
                    n_fail++;
                    $display("FAIL %s slot %0d: got we=%b a=%h d=%h want we=1 a=%h d=%h",
                             tag, i, MemWe, MemAddr, MemData, eaddr[i], edata[i]);
                end
            end else if (MemWe !== 1'b0) begin
                n_fail++;
                $display("FAIL %s slot %0d after end: got we=%b want 0", tag, i, MemWe);
            end
        end
        CpuWrReq = 1'b0;
        n_cmp++;
        if (Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy after clear: got %b want 0", tag, Busy);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        n_cmp++;
        if ({MemWe, MemAddr, MemData, BufSel, NMI_n, Busy, FrameCount} !==
            {1'b0, 15'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_init: got we=%b a=%h d=%h bs=%b nmi=%b busy=%b fc=%0d want 0/0/0/0/1/0/0",
                     MemWe, MemAddr, MemData, BufSel, NMI_n, Busy, FrameCount);
        end
        tick();
        Reset = 1'b0;
        tick();
        // Get into a clear of the new back buffer with NMI active, then reset mid-cycle
        ctrl_wr(1'b1, 8'h3C);
        ctrl_wr(1'b0, 8'h07);
        tick();
        VBlank = 1'b1;
        tick();
        VBlank = 1'b0;
        n_cmp++;
        if (BufSel !== 1'b1 || NMI_n !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_setup swap: got bs=%b nmi=%b want bs=1 nmi=0", BufSel, NMI_n);
        end
        repeat (6) tick();
        n_cmp++;
        if (MemWe !== 1'b1 || MemData !== 8'h3C) begin
            n_fail++;
            $display("FAIL reset_setup clearing: got we=%b d=%h want we=1 d=3c", MemWe, MemData);
        end
        #3;
        Reset = 1'b1;
        #1;
        n_cmp++;
        if ({MemWe, MemAddr, BufSel, NMI_n, Busy, FrameCount} !==
            {1'b0, 15'h0000, 1'b0, 1'b1, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_async: got we=%b a=%h bs=%b nmi=%b busy=%b fc=%0d want 0/0/0/1/0/0",
                     MemWe, MemAddr, BufSel, NMI_n, Busy, FrameCount);
        end
        tick();
        Reset = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (MemWe !== 1'b0 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_resume: got we=%b busy=%b want 0/0", MemWe, Busy);
        end
        // NmiEnable and pending swap were cleared by reset
        VBlank = 1'b1;
        tick();
        n_cmp++;
        if (NMI_n !== 1'b1 || BufSel !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cleared_flags: got nmi=%b bs=%b want 1/0", NMI_n, BufSel);
        end
        VBlank = 1'b0;
        tick();
    endtask

    task automatic test_swap_wait();
        int early;
        apply_reset();
        ctrl_wr(1'b0, 8'h01);
        n_cmp++;
        if (Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL swap_busy_pending: got %b want 1", Busy);
        end
        early = 0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (BufSel !== exp_bs || FrameCount !== 8'(exp_fc)) early++;
        end
        n_cmp++;
        if (early != 0) begin
            n_fail++;
            $display("FAIL swap_before_vblank: got %0d changed cycles want 0", early);
        end
        VBlank = 1'b1;
        #1;
        n_cmp++;
        if (BufSel !== exp_bs) begin
            n_fail++;
            $display("FAIL swap_at_edge: got bs=%b want %b", BufSel, exp_bs);
        end
        tick();
        exp_bs = ~exp_bs;
        exp_fc = (exp_fc + 1) % 256;
        n_cmp++;
        if (BufSel !== exp_bs || FrameCount !== 8'(exp_fc) || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL swap_done: got bs=%b fc=%0d busy=%b want bs=%b fc=%0d busy=0",
                     BufSel, FrameCount, Busy, exp_bs, exp_fc);
        end
        VBlank = 1'b0;
        tick();
    endtask

    task automatic test_clear();
        apply_reset();
        run_clear(8'hE0, 64'h0, 1'b0, "clear_plain");
    endtask

    task automatic test_clear_cpu();
        apply_reset();
        run_clear(8'hE0, 64'h18, 1'b0, "clear_cpu");
    endtask

    task automatic test_nmi_swap_clear();
        logic exp_nmi;
        apply_reset();
        ctrl_wr(1'b1, 8'h1F);
        ctrl_wr(1'b0, 8'h07);
        tick();
        n_cmp++;
        if (NMI_n !== 1'b1 || Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL nmi_pre: got nmi=%b busy=%b want 1/1", NMI_n, Busy);
        end
        VBlank = 1'b1;
        for (int i = 0; i < 25; i++) begin
            CtrlWrite = (i == 6);
            CtrlAddr  = 1'b0;
            CtrlData  = 8'h01;
            if (i == 4) VBlank = 1'b0;
            if (i == 5) VBlank = 1'b1;
            if (i == 10) VBlank = 1'b0;
            tick();
            if (i == 0) begin
                exp_bs = ~exp_bs;
                exp_fc = (exp_fc + 1) % 256;
                n_cmp++;
                if (BufSel !== exp_bs || FrameCount !== 8'(exp_fc)) begin
                    n_fail++;
                    $display("FAIL nmi_first_swap: got bs=%b fc=%0d want bs=%b fc=%0d",
                             BufSel, FrameCount, exp_bs, exp_fc);
                end
            end
            exp_nmi = (i < NL) ? 1'b0 : 1'b1;
            n_cmp++;
            if (NMI_n !== exp_nmi) begin
                n_fail++;
                $display("FAIL nmi_pulse cycle %0d: got %b want %b", i, NMI_n, exp_nmi);
            end
            n_cmp++;
            if (i >= 1 && i <= CW) begin
                if (MemWe !== 1'b1 || MemAddr !== ADDR_W'(i - 1) || MemData !== 8'h1F) begin
                    n_fail++;
                    $display("FAIL nmi_clear cycle %0d: got we=%b a=%h d=%h want we=1 a=%h d=1f",
                             i, MemWe, MemAddr, MemData, i - 1);
                end
            end else if (MemWe !== 1'b0) begin
                n_fail++;
                $display("FAIL nmi_clear idle cycle %0d: got we=%b want 0", i, MemWe);
            end
        end
        CtrlWrite = 1'b0;
        n_cmp++;
        if (BufSel !== exp_bs || FrameCount !== 8'(exp_fc) || Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL nmi_second_pending: got bs=%b fc=%0d busy=%b want bs=%b fc=%0d busy=1",
                     BufSel, FrameCount, Busy, exp_bs, exp_fc);
        end
        VBlank = 1'b1;
        tick();
        exp_bs = ~exp_bs;
        exp_fc = (exp_fc + 1) % 256;
        n_cmp++;
        if (BufSel !== exp_bs || FrameCount !== 8'(exp_fc) || Busy !== 1'b0 || NMI_n !== 1'b1) begin
            n_fail++;
            $display("FAIL nmi_second_swap: got bs=%b fc=%0d busy=%b nmi=%b want bs=%b fc=%0d busy=0 nmi=1",
                     BufSel, FrameCount, Busy, NMI_n, exp_bs, exp_fc);
        end
        VBlank = 1'b0;
        tick();
    endtask

    task automatic test_coincident();
        apply_reset();
        CtrlWrite = 1'b1;
        CtrlAddr  = 1'b0;
        CtrlData  = 8'h01;
        VBlank    = 1'b1;
        tick();
        CtrlWrite = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (BufSel !== 1'b0 || FrameCount !== 8'd0 || Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL coincident_no_swap: got bs=%b fc=%0d busy=%b want 0/0/1", BufSel, FrameCount, Busy);
        end
        VBlank = 1'b0;
        tick();
        ctrl_wr(1'b0, 8'h01);
        VBlank = 1'b1;
        tick();
        n_cmp++;
        if (BufSel !== 1'b1 || FrameCount !== 8'd1 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL coincident_swap: got bs=%b fc=%0d busy=%b want 1/1/0", BufSel, FrameCount, Busy);
        end
        VBlank = 1'b0;
        tick();
        VBlank = 1'b1;
        tick();
        n_cmp++;
        if (BufSel !== 1'b1 || FrameCount !== 8'd1 || NMI_n !== 1'b1) begin
            n_fail++;
            $display("FAIL rerequest_not_queued: got bs=%b fc=%0d nmi=%b want 1/1/1", BufSel, FrameCount, NMI_n);
        end
        VBlank = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int s = 0; s < 256; s++) begin
            ctrl_wr(1'b0, 8'h01);
            repeat ($urandom_range(1, 4)) tick();
            VBlank = 1'b1;
            tick();
            exp_bs = ~exp_bs;
            exp_fc = (exp_fc + 1) % 256;
            n_cmp++;
            if (FrameCount !== 8'(exp_fc) || BufSel !== exp_bs) begin
                n_fail++;
                $display("FAIL wrap swap %0d: got fc=%0d bs=%b want fc=%0d bs=%b",
                         s, FrameCount, BufSel, exp_fc, exp_bs);
            end
            VBlank = 1'b0;
            tick();
        end
    endtask

    task automatic test_random_clear();
        logic [63:0] mask;
        apply_reset();
        for (int r = 0; r < 6; r++) begin
            mask = {$urandom, $urandom} & {$urandom, $urandom} & 64'h0000_00FF_FFFF_FFFF;
            run_clear(8'($urandom), mask, 1'b1, "clear_random");
        end
    endtask

    initial begin
        Reset     = 1'b0;
        VBlank    = 1'b0;
        CpuWrReq  = 1'b0;
        CpuAddr   = '0;
        CpuData   = 8'h00;
        CtrlWrite = 1'b0;
        CtrlAddr  = 1'b0;
        CtrlData  = 8'h00;
        exp_fc    = 0;
        exp_bs    = 1'b0;

        test_reset();
        test_swap_wait();
        test_clear();
        test_clear_cpu();
        test_nmi_swap_clear();
        test_coincident();
        test_wrap();
        test_random_clear();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
